hazard_sequencer: RTL and testbench

Pipeline hazard and sequencing unit for the 5-stage CPU (IF/ID/EX/MEM/WB). It consumes the 5-bit opcode in ID, register addresses, and the decoded EX/MEM control already produced by the controller, and drives the pipeline-register enables and flushes. It handles load-use and flag stalls, redirect flushes for taken jumps and branches, the two-cycle return sequence, and data-memory wait freezes. It also keeps saturating performance counters.

---
 rtl/hazard_sequencer_pkg.sv | 33 +++
 rtl/hazard_sequencer_sat_counter.sv | 17 +
 rtl/hazard_sequencer.sv | 101 ++++++++++
 tb/tb_hazard_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sequencer_pkg.sv
// hazard_pkg: opcode classes, sequencer states and PC-source codes shared with the controller
package hazard_pkg;

    typedef enum logic [2:0] {
        C_ALU_REG,
        C_ALU_IMM,
        C_MEM,
        C_BRANCH,
        C_SHIFT,
        C_JUMP,
        C_RET
    } op_class_e;

    typedef enum logic [1:0] {
        RUN,
        RET2,
        FREEZE
    } state_e;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    function automatic op_class_e classify(input logic [4:0] inst);
        return inst[4:3] == 2'b00  ? C_ALU_REG :
               inst[4:3] == 2'b01  ? C_ALU_IMM :
               inst[4:2] == 3'b100 ? C_MEM     :
               inst[4:2] == 3'b101 ? C_BRANCH  :
               inst[4:2] == 3'b110 ? C_SHIFT   :
               inst[1]             ? C_RET     : C_JUMP;
    endfunction

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// sat_counter: event counter that sticks at all-ones; clear takes priority
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    // count up on inc, hold at the top value
    always_ff @(posedge clk) begin
        if (clear) count <= '0;
        else if (inc && !(&count)) count <= count + W'(1);
    end

endmodule

// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline enables/flushes for stalls, redirects, returns and memory-wait freezes
module hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_inst,
    input  logic [2:0]       id_rs1,
    input  logic [2:0]       id_rs2,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [2:0]       ex_rd,
    input  logic             ex_change_zc,
    input  logic [1:0]       ex_pcsrc,
    input  logic             ex_pop,
    input  logic             mem_access,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirect_count
);

    state_e    state, saved, next_state, eff;
    op_class_e cls;
    logic      freeze, redirect, hazard, uses_rs1, uses_rs2, load_use, redirect_inc;
    logic      unused_regwrite;

    assign unused_regwrite = ex_regwrite;
    assign cls      = classify(id_inst);
    assign uses_rs1 = !(cls inside {C_BRANCH, C_JUMP, C_RET});
    assign uses_rs2 = cls == C_ALU_REG || (cls == C_MEM && id_inst[0]);
    assign load_use = ex_memread && ((uses_rs1 && ex_rd == id_rs1) || (uses_rs2 && ex_rd == id_rs2));
    assign hazard   = load_use || (cls == C_BRANCH && ex_change_zc);
    assign freeze   = mem_access && !mem_ready;
    assign redirect = ex_pcsrc != PCSRC_SEQ;
    // while frozen, behave as the state that was interrupted once memory is ready
    assign eff      = state == FREEZE ? saved : state;
    assign redirect_inc = !freeze && eff == RUN && (ex_pop || redirect);

    // state register; remember the interrupted state when a freeze begins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            saved <= RUN;
        end else begin
            state <= next_state;
            if (freeze && state != FREEZE) saved <= state;
        end
    end

    // next state: freeze holds, a return takes one extra cycle, everything else runs
    always_comb begin
        next_state = freeze ? FREEZE : (eff == RUN && ex_pop) ? RET2 : RUN;
    end

    // enables and flushes in priority order
    always_comb begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        {ifid_flush, idex_flush} = 2'b00;
        if (!rst_n) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            {ifid_flush, idex_flush} = 2'b11;
        end else if (freeze) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
        end else if (eff == RET2) begin
            ifid_flush = 1'b1;
        end else if (ex_pop) begin
            pc_en = 1'b0;
            {ifid_flush, idex_flush} = 2'b11;
        end else if (redirect) begin
            {ifid_flush, idex_flush} = 2'b11;
        end else if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (!rst_n),
        .inc   (!pc_en),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk   (clk),
        .clear (!rst_n),
        .inc   (redirect_inc),
        .count (redirect_count)
    );

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb_hazard_sequencer: table vectors, corner sequences and random stimulus against a behavioural model
module tb_hazard_sequencer;

    localparam int CNT_W = 8;
    localparam int MAX   = (1 << CNT_W) - 1;

    typedef struct {
        logic       rst_n;
        logic [4:0] inst;
        logic [2:0] rs1;
        logic [2:0] rs2;
        logic       mr;
        logic [2:0] rd;
        logic       zc;
        logic [1:0] pcsrc;
        logic       pop;
        logic       acc;
        logic       rdy;
        logic [6:0] exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_inst;
    logic [2:0]       id_rs1, id_rs2, ex_rd;
    logic             ex_memread, ex_regwrite, ex_change_zc, ex_pop, mem_access, mem_ready;
    logic [1:0]       ex_pcsrc;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic [CNT_W-1:0] stall_cycles, redirect_count;
    logic [6:0]       outs;

    int checks = 0;
    int failures = 0;
    bit m_ret2 = 1'b0;
    int m_stall = 0;
    int m_redir = 0;
    vec_t tbl[16];

    always #5 clk = ~clk;

    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

    hazard_sequencer #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_inst        (id_inst),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_memread     (ex_memread),
        .ex_regwrite    (ex_regwrite),
        .ex_rd          (ex_rd),
        .ex_change_zc   (ex_change_zc),
        .ex_pcsrc       (ex_pcsrc),
        .ex_pop         (ex_pop),
        .mem_access     (mem_access),
        .mem_ready      (mem_ready),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .idex_en        (idex_en),
        .exmem_en       (exmem_en),
        .memwb_en       (memwb_en),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .stall_cycles   (stall_cycles),
        .redirect_count (redirect_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // expected {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush} from the rules, using opcode ranges
    function automatic logic [6:0] model_out();
        bit br = id_inst >= 5'd20 && id_inst <= 5'd23;
        bit u1 = !br && id_inst < 5'd28;
        bit u2 = id_inst < 5'd8 || (id_inst >= 5'd16 && id_inst < 5'd20 && id_inst[0]);
        bit hz = (ex_memread && ((u1 && ex_rd == id_rs1) || (u2 && ex_rd == id_rs2))) || (br && ex_change_zc);
        if (!rst_n) return 7'b0000011;
        if (mem_access && !mem_ready) return 7'b0000000;
        if (m_ret2) return 7'b1111110;
        if (ex_pop) return 7'b0111111;
        if (ex_pcsrc != 2'b00) return 7'b1111111;
        if (hz) return 7'b0011101;
        return 7'b1111100;
    endfunction

    task automatic cycle(input string name, input logic [6:0] texp, input bit use_tbl);
        logic [6:0] e;
        @(negedge clk);
        e = model_out();
        check({name, "_model"}, 32'(outs), 32'(e));
        if (use_tbl) check({name, "_table"}, 32'(outs), 32'(texp));
        if (!rst_n) begin
            m_ret2 = 1'b0;
            m_stall = 0;
            m_redir = 0;
        end else begin
            if (!e[6] && m_stall < MAX) m_stall++;
            if (!(mem_access && !mem_ready)) begin
                if (m_ret2) m_ret2 = 1'b0;
                else if (ex_pop) begin
                    m_ret2 = 1'b1;
                    if (m_redir < MAX) m_redir++;
                end else if (ex_pcsrc != 2'b00 && m_redir < MAX) m_redir++;
            end
        end
        @(posedge clk);
        #1;
        check({name, "_stall_cycles"}, 32'(stall_cycles), 32'(m_stall));
        check({name, "_redirect_count"}, 32'(redirect_count), 32'(m_redir));
    endtask

    task automatic drive(input vec_t v);
        rst_n = v.rst_n;
        id_inst = v.inst;
        id_rs1 = v.rs1;
        id_rs2 = v.rs2;
        ex_memread = v.mr;
        ex_regwrite = v.mr;
        ex_rd = v.rd;
        ex_change_zc = v.zc;
        ex_pcsrc = v.pcsrc;
        ex_pop = v.pop;
        mem_access = v.acc;
        mem_ready = v.rdy;
    endtask

    task automatic idle();
        drive('{1'b1, 5'd0, 3'd1, 3'd2, 1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 7'b0});
    endtask

    initial begin
        tbl[0]  = '{1'b1, 5'b00000, 3'd1, 3'd3, 1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b0011101};
        tbl[1]  = '{1'b1, 5'b00000, 3'd3, 3'd1, 1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b0011101};
        tbl[2]  = '{1'b1, 5'b01000, 3'd1, 3'd3, 1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b1111100};
        tbl[3]  = '{1'b1, 5'b10000, 3'd0, 3'd3, 1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b1111100};
        tbl[4]  = '{1'b1, 5'b10001, 3'd0, 3'd3, 1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b0011101};
        tbl[5]  = '{1'b1, 5'b10100, 3'd3, 3'd3, 1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b1111100};
        tbl[6]  = '{1'b1, 5'b10100, 3'd0, 3'd0, 1'b0, 3'd3, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 7'b0011101};
        tbl[7]  = '{1'b1, 5'b11100, 3'd3, 3'd3, 1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b1111100};
        tbl[8]  = '{1'b1, 5'b11000, 3'd3, 3'd0, 1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b0011101};
        tbl[9]  = '{1'b1, 5'b00000, 3'd3, 3'd3, 1'b0, 3'd3, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 7'b1111100};
        tbl[10] = '{1'b1, 5'b00000, 3'd3, 3'd3, 1'b1, 3'd3, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 7'b1111111};
        tbl[11] = '{1'b1, 5'b01000, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0, 7'b1111111};
        tbl[12] = '{1'b1, 5'b00000, 3'd1, 3'd2, 1'b1, 3'd3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 7'b1111100};
        tbl[13] = '{1'b1, 5'b00000, 3'd1, 3'd2, 1'b0, 3'd3, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 7'b0000000};
        tbl[14] = '{1'b1, 5'b11110, 3'd0, 3'd0, 1'b0, 3'd0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 7'b1111100};
        tbl[15] = '{1'b0, 5'b00000, 3'd3, 3'd3, 1'b1, 3'd3, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 7'b0000011};

        idle();
        rst_n = 1'b0;
        cycle("reset", 7'b0000011, 1'b1);
        check("reset_stall_zero", 32'(stall_cycles), 32'd0);
        check("reset_redir_zero", 32'(redirect_count), 32'd0);
        foreach (tbl[i]) begin
            drive(tbl[i]);
            cycle($sformatf("vec%0d", i), tbl[i].exp, 1'b1);
        end

        idle();
        ex_pop = 1'b1;
        cycle("ret_entry", 7'b0111111, 1'b1);
        idle();
        cycle("ret2", 7'b1111110, 1'b1);
        cycle("ret_done", 7'b1111100, 1'b1);

        idle();
        ex_pop = 1'b1;
        ex_pcsrc = 2'b10;
        cycle("retjmp_entry", 7'b0111111, 1'b1);
        idle();
        ex_pcsrc = 2'b10;
        cycle("retjmp_ret2", 7'b1111110, 1'b1);

        idle();
        ex_pop = 1'b1;
        cycle("frz_ret_entry", 7'b0111111, 1'b1);
        idle();
        mem_access = 1'b1;
        mem_ready = 1'b0;
        repeat (3) cycle("frz_in_ret2", 7'b0000000, 1'b1);
        mem_ready = 1'b1;
        cycle("frz_release_ret2", 7'b1111110, 1'b1);
        idle();
        cycle("frz_after", 7'b1111100, 1'b1);

        idle();
        ex_pop = 1'b1;
        cycle("rstfrz_ret_entry", 7'b0111111, 1'b1);
        idle();
        mem_access = 1'b1;
        mem_ready = 1'b0;
        cycle("rstfrz_frozen", 7'b0000000, 1'b1);
        rst_n = 1'b0;
        cycle("rstfrz_reset", 7'b0000011, 1'b1);
        idle();
        cycle("rstfrz_run", 7'b1111100, 1'b1);
        check("rstfrz_stall_zero", 32'(stall_cycles), 32'd0);
        check("rstfrz_redir_zero", 32'(redirect_count), 32'd0);

        idle();
        mem_access = 1'b1;
        mem_ready = 1'b0;
        repeat ((1 << CNT_W) + 5) cycle("sat", 7'b0000000, 1'b1);
        check("stall_saturated", 32'(stall_cycles), 32'(MAX));

        idle();
        for (int n = 0; n < 600; n++) begin
            rst_n = $urandom_range(63) != 0;
            id_inst = 5'($urandom);
            id_rs1 = 3'($urandom);
            id_rs2 = 3'($urandom);
            ex_memread = 1'($urandom);
            ex_regwrite = 1'($urandom);
            ex_rd = 3'($urandom);
            ex_change_zc = $urandom_range(3) == 0;
            ex_pcsrc = $urandom_range(3) == 0 ? 2'($urandom) : 2'b00;
            ex_pop = $urandom_range(7) == 0;
            mem_access = $urandom_range(2) == 0;
            mem_ready = 1'($urandom);
            cycle("rand", 7'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
